// File: rtl/gtech_sel_pkg.sv
// Shared types, grant encodings and round-robin pick helper for the AOI222 select generator.
package gtech_sel_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sel_state_t;

  localparam logic [2:0] G0    = 3'b001;
  localparam logic [2:0] G1    = 3'b010;
  localparam logic [2:0] G2    = 3'b100;
  localparam logic [2:0] GNONE = 3'b000;

  // Clear value of the last-granted index, so the first scan order is 0,1,2.
  localparam logic [1:0] LAST_RST = 2'd2;

  // First set request bit scanning last+1, last+2, last+3 (mod 3).
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [2:0] g;
    g = GNONE;
    case (last)
      2'd0: begin
        if      (req[1]) g = G1;
        else if (req[2]) g = G2;
        else if (req[0]) g = G0;
      end
      2'd1: begin
        if      (req[2]) g = G2;
        else if (req[0]) g = G0;
        else if (req[1]) g = G1;
      end
      default: begin
        if      (req[0]) g = G0;
        else if (req[1]) g = G1;
        else if (req[2]) g = G2;
      end
    endcase
    return g;
  endfunction

  function automatic logic [1:0] oh_idx(input logic [2:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[1]) idx = 2'd1;
    if (oh[2]) idx = 2'd2;
    return idx;
  endfunction

endpackage

// File: rtl/gtech_aoi222_vec.sv
// Bitwise AOI222 of three words against their grant bits; purely combinational.
module gtech_aoi222_vec #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic [2:0]       i_sel,
  output logic [WIDTH-1:0] o_zn
);

  assign o_zn = ~((i_a & {WIDTH{i_sel[0]}}) |
                  (i_b & {WIDTH{i_sel[1]}}) |
                  (i_c & {WIDTH{i_sel[2]}}));

endmodule

// File: rtl/gtech_rr_sel3.sv
// Round-robin 3-way select generator with hold timeout; grant is 1 cycle after request,
// ZN lags grant by 1 cycle. Release on DONE or dropped request has priority over timeout.
module gtech_rr_sel3 #(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 16,
  parameter int CW       = 8
) (
  input  logic             CP,
  input  logic             CD,
  input  logic [2:0]       REQ,
  input  logic [2:0]       DONE,
  input  logic [WIDTH-1:0] DA,
  input  logic [WIDTH-1:0] DB,
  input  logic [WIDTH-1:0] DC,
  output logic [2:0]       GNT,
  output logic             GNT_VLD,
  output logic [WIDTH-1:0] ZN,
  output logic             TIMEOUT
);

  import gtech_sel_pkg::*;

  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  sel_state_t      r_state, w_state_nxt;
  logic [2:0]      r_gnt, w_gnt_nxt;
  logic            r_gnt_vld;
  logic [1:0]      r_last, w_last_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_to, w_to_nxt;
  logic [WIDTH-1:0] r_zn;
  logic [WIDTH-1:0] w_aoi;
  logic [2:0]      w_pick;
  logic            w_rel;

  assign w_pick = rr_pick(REQ, r_last);
  // In GRANT r_last is the holder, so the holder is last in the scan order.
  assign w_rel  = |(r_gnt & (DONE | ~REQ));

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_to_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        w_gnt_nxt = GNONE;
        w_cnt_nxt = '0;
        if (w_pick != GNONE) begin
          w_gnt_nxt   = w_pick;
          w_last_nxt  = oh_idx(w_pick);
          w_cnt_nxt   = CNT_ONE;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (w_rel) begin
          if (w_pick != GNONE) begin
            w_gnt_nxt  = w_pick;
            w_last_nxt = oh_idx(w_pick);
            w_cnt_nxt  = CNT_ONE;
          end else begin
            w_gnt_nxt   = GNONE;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end
        end else if (r_cnt == HOLD_LIM) begin
          w_gnt_nxt   = GNONE;
          w_cnt_nxt   = '0;
          w_to_nxt    = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_gnt_nxt   = GNONE;
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  gtech_aoi222_vec #(
    .WIDTH (WIDTH)
  ) u_aoi (
    .i_a   (DA),
    .i_b   (DB),
    .i_c   (DC),
    .i_sel (r_gnt),
    .o_zn  (w_aoi)
  );

  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      r_state   <= IDLE;
      r_gnt     <= GNONE;
      r_gnt_vld <= 1'b0;
      r_last    <= LAST_RST;
      r_cnt     <= '0;
      r_to      <= 1'b0;
      r_zn      <= '1;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_vld <= |w_gnt_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_to      <= w_to_nxt;
      r_zn      <= w_aoi;
    end
  end

  assign GNT     = r_gnt;
  assign GNT_VLD = r_gnt_vld;
  assign ZN      = r_zn;
  assign TIMEOUT = r_to;

  a_gnt_onehot: assert property (@(posedge CP) disable iff (!CD) $onehot0(r_gnt));

endmodule

// File: tb/tb_gtech_rr_sel3.sv
// Randomized and directed bench for gtech_rr_sel3 against an index-based arbitration model.
module tb_gtech_rr_sel3;

  localparam int WIDTH    = 8;
  localparam int HOLD_MAX = 16;

  logic       CP;
  logic       CD;
  logic [2:0] REQ;
  logic [2:0] DONE;
  logic [7:0] DA, DB, DC;
  logic [2:0] GNT;
  logic       GNT_VLD;
  logic [7:0] ZN;
  logic       TIMEOUT;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: holder index (-1 idle), last winner index, cycles held.
  int         m_hold;
  int         m_last;
  int         m_cnt;
  logic       m_to;
  logic [7:0] m_zn;

  gtech_rr_sel3 #(
    .WIDTH    (WIDTH),
    .HOLD_MAX (HOLD_MAX),
    .CW       (8)
  ) dut (
    .CP      (CP),
    .CD      (CD),
    .REQ     (REQ),
    .DONE    (DONE),
    .DA      (DA),
    .DB      (DB),
    .DC      (DC),
    .GNT     (GNT),
    .GNT_VLD (GNT_VLD),
    .ZN      (ZN),
    .TIMEOUT (TIMEOUT)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mpick(input logic [2:0] req, input int last);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (last + k) % 3;
      if (((req >> i) & 3'b001) != 3'b000) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_hold = -1;
    m_last = 2;
    m_cnt  = 0;
    m_to   = 1'b0;
    m_zn   = 8'hFF;
  endtask

  task automatic step(input logic [2:0] req, input logic [2:0] done,
                      input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [23:0] words;
    int p;
    REQ = req; DONE = done; DA = a; DB = b; DC = c;
    words = {c, b, a};
    m_zn  = (m_hold < 0) ? 8'hFF : ~8'(words >> (8 * m_hold));
    m_to  = 1'b0;
    if (m_hold < 0) begin
      p = mpick(req, m_last);
      if (p >= 0) begin m_hold = p; m_last = p; m_cnt = 1; end
    end else if ((((done >> m_hold) & 3'b001) != 3'b000) ||
                 (((req >> m_hold) & 3'b001) == 3'b000)) begin
      p = mpick(req, m_hold);
      if (p >= 0) begin m_hold = p; m_last = p; m_cnt = 1; end
      else m_hold = -1;
    end else if (m_cnt == HOLD_MAX) begin
      m_hold = -1;
      m_to   = 1'b1;
    end else begin
      m_cnt++;
    end
    @(posedge CP);
    #1;
    chk("gnt", 32'(GNT), (m_hold < 0) ? 32'd0 : (32'd1 << m_hold));
    chk("gnt_vld", 32'(GNT_VLD), 32'(m_hold >= 0));
    chk("timeout", 32'(TIMEOUT), 32'(m_to));
    chk("zn", 32'(ZN), 32'(m_zn));
  endtask

  initial begin
    logic [2:0] rq;
    logic [2:0] dn;
    int n_on;
    CD = 1'b0; REQ = '0; DONE = '0; DA = '0; DB = '0; DC = '0;
    model_reset();
    #12;
    chk("rst_gnt", 32'(GNT), 32'd0);
    chk("rst_vld", 32'(GNT_VLD), 32'd0);
    chk("rst_zn", 32'(ZN), 32'hFF);
    chk("rst_to", 32'(TIMEOUT), 32'd0);
    CD = 1'b1;

    // Single requester with data path.
    step(3'b001, 3'b000, 8'h3C, 8'h00, 8'h00);
    chk("sr_gnt", 32'(GNT), 32'd1);
    step(3'b001, 3'b000, 8'h3C, 8'h00, 8'h00);
    chk("sr_zn", 32'(ZN), 32'hC3);
    step(3'b001, 3'b000, 8'h3C, 8'h00, 8'h00);
    step(3'b001, 3'b000, 8'h3C, 8'h00, 8'h00);
    step(3'b000, 3'b001, 8'h3C, 8'h00, 8'h00);
    chk("sr_rel", 32'(GNT), 32'd0);
    step(3'b000, 3'b000, 8'h3C, 8'h00, 8'h00);
    chk("sr_zn_idle", 32'(ZN), 32'hFF);

    // Clear in the middle of a grant, no clock edge involved.
    step(3'b010, 3'b000, 8'h11, 8'h22, 8'h33);
    step(3'b010, 3'b000, 8'h11, 8'h22, 8'h33);
    chk("mr_pre", 32'(GNT), 32'd2);
    CD = 1'b0;
    #1;
    chk("mr_gnt", 32'(GNT), 32'd0);
    chk("mr_vld", 32'(GNT_VLD), 32'd0);
    chk("mr_zn", 32'(ZN), 32'hFF);
    chk("mr_to", 32'(TIMEOUT), 32'd0);
    #2;
    CD = 1'b1;
    model_reset();

    // Round-robin fairness with back-to-back handover.
    step(3'b111, 3'b000, 8'hA5, 8'h5A, 8'h0F);
    chk("rr0", 32'(GNT), 32'd1);
    step(3'b111, 3'b001, 8'hA5, 8'h5A, 8'h0F);
    chk("rr1", 32'(GNT), 32'd2);
    step(3'b111, 3'b010, 8'hA5, 8'h5A, 8'h0F);
    chk("rr2", 32'(GNT), 32'd4);
    step(3'b111, 3'b100, 8'hA5, 8'h5A, 8'h0F);
    chk("rr3", 32'(GNT), 32'd1);
    step(3'b000, 3'b001, 8'hA5, 8'h5A, 8'h0F);
    step(3'b000, 3'b000, 8'hA5, 8'h5A, 8'h0F);

    // Timeout on a single held request.
    n_on = 0;
    for (int s = 1; s <= 18; s++) begin
      step(3'b010, 3'b000, 8'h01, 8'h02, 8'h03);
      if (s <= 17 && GNT == 3'b010) n_on++;
      if (s == 17) chk("to_pulse", 32'(TIMEOUT), 32'd1);
      if (s == 18) chk("to_regrant", 32'(GNT), 32'd2);
    end
    chk("to_hold", 32'(n_on), 32'(HOLD_MAX));
    step(3'b000, 3'b010, 8'h01, 8'h02, 8'h03);

    // Release in the same cycle the hold limit is reached.
    for (int s = 1; s <= HOLD_MAX; s++) step(3'b011, 3'b000, 8'h44, 8'h55, 8'h66);
    step(3'b011, 3'b001, 8'h44, 8'h55, 8'h66);
    chk("sim_to", 32'(TIMEOUT), 32'd0);
    chk("sim_gnt", 32'(GNT), 32'd2);
    step(3'b000, 3'b010, 8'h44, 8'h55, 8'h66);

    // Stray DONE from a non-holder, then holder drops its request.
    step(3'b001, 3'b000, 8'h77, 8'h88, 8'h99);
    step(3'b101, 3'b100, 8'h77, 8'h88, 8'h99);
    chk("stray", 32'(GNT), 32'd1);
    step(3'b100, 3'b000, 8'h77, 8'h88, 8'h99);
    chk("drop", 32'(GNT), 32'd4);
    step(3'b000, 3'b100, 8'h77, 8'h88, 8'h99);

    // Random traffic: sticky requests so timeouts occur, sparse DONE.
    rq = 3'b000;
    for (int s = 0; s < 1500; s++) begin
      if ($urandom_range(0, 3) == 0) rq = 3'($urandom_range(0, 7));
      dn = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      step(rq, dn, 8'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gtech_rr_sel3.md
Name: gtech_rr_sel3

Overview:
- Sequential select generator that drives the pair-enable side of an AOI222 inverting 3:1 data path.
- Round-robin arbitrates three requesters and holds a one-hot grant until release or timeout.
- Drives the grant onto a WIDTH-bit AOI222 datapath and registers the inverted selected word.
- Sits in front of GTECH AOI222-based shared-bus muxes, in the slot a hand-built select decoder would otherwise fill.

Parameters:
- WIDTH, 8, data width of each input word and of ZN.
- HOLD_MAX, 16, maximum consecutive cycles one grant is held before forced revoke; legal range 2..255.
- CW, 8, width of the hold counter; must satisfy 2^CW > HOLD_MAX.

Ports:
- CP  in  1  clock, rising edge.
- CD  in  1  asynchronous active-low clear.
- REQ  in  3  request per requester; bit i = requester i.
- DONE  in  3  release strobe per requester; honoured only for the current holder.
- DA  in  WIDTH  data word of requester 0.
- DB  in  WIDTH  data word of requester 1.
- DC  in  WIDTH  data word of requester 2.
- GNT  out  3  registered one-hot grant, or 000 when idle.
- GNT_VLD  out  1  registered; equals |GNT.
- ZN  out  WIDTH  registered ~((DA&GNT0)|(DB&GNT1)|(DC&GNT2)), bitwise.
- TIMEOUT  out  1  one-cycle pulse when a grant is force-revoked.

Behaviour:
- Clear: CD low asynchronously forces GNT=000, GNT_VLD=0, ZN=all ones, TIMEOUT=0, state=IDLE, hold count=0, last=2. With last=2 the first priority order is 0,1,2.
- Reset mid-grant: all outputs return to the reset values within the same CD-low interval, with no clock needed. Arbitration resumes on the first CP edge after CD rises.
- States: IDLE, GRANT.
- IDLE, REQ==000: stay in IDLE; GNT=000.
- IDLE, REQ!=000: pick the first set REQ bit scanning last+1, last+2, last+3 (mod 3). Register that one-hot on GNT at the next edge. Latency from REQ to GNT is 1 cycle. Set last=pick, count=1, go to GRANT.
- GRANT release: occurs when DONE[h]=1, or REQ[h]=0 (request dropped), for holder h. Release has priority over timeout in the same cycle.
- GRANT release, other requests pending: at the next edge GNT moves directly to the next round-robin winner, back-to-back with no idle cycle. h itself is eligible, at lowest priority. count=1.
- GRANT release, no requests: at the next edge go to IDLE with GNT=000.
- GRANT timeout: count==HOLD_MAX with no release. At the next edge GNT is revoked (000), TIMEOUT pulses for that one cycle, state goes to IDLE, and last=h, so h is lowest priority next time.
- After a timeout, IDLE always lasts at least 1 cycle.
- GRANT otherwise: count increments. The counter saturates, never wraps.
- DONE bits of non-holders and DONE in IDLE are ignored.
- ZN: registered every cycle from the current registered GNT and the live DA/DB/DC. It lags GNT by 1 cycle. With GNT=000, ZN=all ones.
- GNT is never more than one-hot. An assertion must flag a violation.

Decomposition:
- Package gtech_sel_pkg:
  - state enum {IDLE, GRANT};
  - one-hot constants G0=001, G1=010, G2=100, GNONE=000;
  - function rr_pick(req[2:0], last[1:0]) returning a one-hot.
- Sub-module gtech_aoi222_vec (WIDTH): purely combinational bitwise AOI222 of the three words against the grant bits. The top registers its output into ZN.

Test Plan:
- Reset/idle: CD low mid-grant with GNT=010 -> GNT=000, ZN=FF, TIMEOUT=0 immediately, without a clock edge.
- Single requester: REQ=001 at cycle 0 -> GNT=001 at cycle 1. DA=3C -> ZN=C3 at cycle 2. DONE[0] at cycle 4 with REQ=000 -> GNT=000 at cycle 5 and ZN=FF at cycle 6.
- Round-robin fairness: REQ=111 held, each holder pulses DONE one cycle after being granted -> GNT sequence 001, 010, 100, 001, with no idle cycles.
- Timeout: REQ=010 held, no DONE, HOLD_MAX=16 -> GNT=010 for exactly 16 cycles, then GNT=000 with TIMEOUT=1 for one cycle, then GNT=010 again one cycle later.
- Simultaneous release and timeout: DONE[h] asserted on the cycle count==HOLD_MAX with another REQ pending -> no TIMEOUT pulse, and GNT moves directly to the next winner.
- Request drop and stray DONE: holder 0 drops REQ without DONE -> treated as release. DONE[2] pulsed while 0 holds -> no effect on GNT.
